pcie_dma_rx_req_decoder: RTL
============================

// Module: pcie_dma_rx_req_decoder
// PURPOSE
//  Sits directly downstream of the PCIe core RX stream (pcie_dma64_in_type fields, 64-bit beats).
//  Parses Memory Read/Write request TLPs (3DW/4DW headers) into a request channel plus a 32-bit write-data
//  channel for the BAR register/DMA target. Unsupported, BAR-masked and poisoned TLPs are consumed and dropped.
// PARAMETERS
//  BAR_MASK   7'h01   bar_hit bits accepted; TLP with (bar_hit & BAR_MASK)==0 is dropped
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   asynchronous reset, active-high
//  i_rx_data      in   64  TLP beat; lower DW = earlier DW
//  i_rx_strob     in   8   byte enables of beat (only [7:4] checked, on last beat)
//  i_rx_last      in   1   last beat of TLP
//  i_rx_bar_hit   in   7   BAR hit, valid on first beat
//  i_rx_err_fwd   in   1   packet poisoned by core
//  i_rx_ecrc_err  in   1   ECRC error, sampled on last beat
//  i_rx_valid     in   1   beat valid
//  o_rx_ready     out  1   beat accepted when valid&ready
//  o_req_valid/i_req_ready  out/in 1   request handshake
//  o_req_write    out  1   1=MWr, 0=MRd
//  o_req_addr     out  64  DW-aligned byte address ([1:0]=0; [63:32]=0 for 3DW)
//  o_req_len      out  11  length in DW, 1..1024
//  o_req_fbe/o_req_lbe out 4  first/last DW byte enables
//  o_req_rid      out  16  requester ID;  o_req_tag out 8;  o_req_tc out 3;  o_req_attr out 2
//  o_req_bar      out  3   index of lowest accepted set bar_hit bit (6 = expansion ROM)
//  o_wr_valid/i_wr_ready    out/in 1   write-data handshake
//  o_wr_data      out  32  one DW per beat;  o_wr_strb out 4;  o_wr_last out 1
//  o_err_unsup    out  1   1-clk pulse: unsupported type/BAR dropped
//  o_err_poison   out  1   1-clk pulse: EP bit or err_fwd set, TLP dropped
//  o_err_malformed out 1   1-clk pulse: length vs last mismatch
//  o_err_ecrc     out  1   1-clk pulse: ecrc_err on last accepted beat
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; o_rx_ready forced 0 while i_rst=1.
//  Header fields: DW0: fmt[31:29] type[28:24] tc[22:20] EP[14] attr[13:12] len[9:0] (0 => 1024).
//   DW1: rid[31:16] tag[15:8] lbe[7:4] fbe[3:0]. 3DW: DW2 = addr[31:2]. 4DW: DW2 = addr[63:32], DW3 = addr[31:2].
//   MRd: fmt 000/001; MWr: fmt 010/011; type must be 00000. Anything else is unsupported.
//  States:
//   IDLE: ready=1; beat0 accepted -> latch DW0/DW1/bar_hit -> HDR1. If last set on beat0 -> pulse malformed, stay IDLE.
//   HDR1: ready=1; beat1 accepted -> decode:
//    - unsupported or BAR miss -> unsup pulse, then DROP (or IDLE if last).
//    - EP|err_fwd (either beat) -> poison pulse, then DROP/IDLE.
//    - otherwise -> REQ.
//    3DW MWr: beat1[63:32] = first data DW, loaded into the DW buffer.
//   REQ: ready=0; o_req_valid=1, fields stable until i_req_ready. On handshake: MRd -> IDLE; MWr -> DATA.
//    MRd that did not end on beat1 is malformed -> DROP.
//   DATA: 2-DW buffer; ready=1 only when buffer empty. An accepted beat loads both DWs.
//    Buffer emits one DW per i_wr_ready. 11-bit remaining counter decrements per emitted DW.
//    Strobes: first DW = fbe; last DW = lbe (fbe if len=1); others 4'hF.
//    o_wr_last when counter=1. Surplus DWs in the final beat are discarded.
//    - Input last arrives with DWs still owed -> emit buffered DWs, force o_wr_last on the final one, pulse malformed, -> IDLE.
//    - Counter reaches 0 with input not last -> pulse malformed, -> DROP.
//   DROP: ready=1; discard beats until valid&last -> IDLE.
//  Latency: o_req_valid 1 clk after beat1 handshake. A DW appears on o_wr_* 1 clk after its beat handshake.
//  Sustained rate is 1 DW/clk.
//  o_err_ecrc pulses 1 clk after any accepted last beat with ecrc_err=1, in any state; it does not alter flow.
//  All error pulses are registered; simultaneous errors may pulse together.
//  Async reset mid-TLP: return to IDLE, drop pending request/data. Remaining beats of that TLP are parsed as a new header.
//  valid/ready handshakes: outputs hold valid and fields stable until ready; never drop valid without a handshake.
// TESTING
//  3DW MWr len=1, addr 0x1000, fbe=F, bar_hit=1 -> req{write=1, addr=0x1000, len=1}; 1 DW with last=1, strb=F.
//  4DW MWr len=3, addr 0x1_0000_0040, fbe=E, lbe=3, with i_wr_ready toggling -> 3 DWs, strb E/F/3, last on 3rd, no loss.
//  MRd 3DW len=0, tag 0x2A, rid 0x0100 -> req{write=0, len=1024, tag=0x2A, rid=0x0100}; no o_wr_valid.
//  bar_hit=7'h02 (BAR_MASK=1) or type=Cfg -> o_err_unsup pulse, beats drained, no request.
//  MWr len=4 ending after 2 DWs -> 2 DWs, 2nd with last, o_err_malformed; err_fwd=1 -> o_err_poison, no request.
//  i_rst asserted during DATA of len=8 MWr -> all outputs 0; next clean MRd decoded correctly.

Source files
------------

// File: rtl/pcie_dma_rx_req_decoder.sv
// Parses PCIe Memory Read/Write request TLPs from a 64-bit RX beat stream into a request
// channel and a 32-bit write-data channel; unsupported, BAR-masked and poisoned TLPs are dropped.
module pcie_dma_rx_req_decoder #(
  parameter logic [6:0] BAR_MASK = 7'h01
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_rx_data,
  input  logic [7:0]  i_rx_strob,
  input  logic        i_rx_last,
  input  logic [6:0]  i_rx_bar_hit,
  input  logic        i_rx_err_fwd,
  input  logic        i_rx_ecrc_err,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic        o_req_write,
  output logic [63:0] o_req_addr,
  output logic [10:0] o_req_len,
  output logic [3:0]  o_req_fbe,
  output logic [3:0]  o_req_lbe,
  output logic [15:0] o_req_rid,
  output logic [7:0]  o_req_tag,
  output logic [2:0]  o_req_tc,
  output logic [1:0]  o_req_attr,
  output logic [2:0]  o_req_bar,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_strb,
  output logic        o_wr_last,
  output logic        o_err_unsup,
  output logic        o_err_poison,
  output logic        o_err_malformed,
  output logic        o_err_ecrc
);

  typedef enum logic [2:0] {StIdle, StHdr1, StReq, StData, StDrop} state_e;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [10:0] len;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [2:0]  bar;
  } req_t;

  state_e           state_q, state_d;
  logic [31:0]      dw0_q, dw0_d, dw1_q, dw1_d;
  logic [6:0]       bar_hit_q, bar_hit_d;
  logic             fwd_q, fwd_d;
  logic             hdr_last_q, hdr_last_d;
  req_t             req_q, req_d;
  logic [1:0][31:0] dbuf_q, dbuf_d;
  logic [1:0]       dbuf_cnt_q, dbuf_cnt_d;
  logic             rd_q, rd_d;
  logic [10:0]      rem_q, rem_d;
  logic             in_last_q, in_last_d;
  logic             first_q, first_d;
  logic             unsup_q, unsup_d, poison_q, poison_d, malf_q, malf_d, ecrc_q;

  logic        rx_ready, rx_fire, pop;
  logic [1:0]  cnt_after, load_cnt;
  logic [10:0] rem_after, hdr_len;
  logic [2:0]  fmt;
  logic        is_mrd, is_mwr, is_4dw, supported, poisoned, hdr_has_data;
  logic [6:0]  bar_sel;
  logic [2:0]  bar_idx;

  assign fmt          = dw0_q[31:29];
  assign is_mrd       = (fmt[2:1] == 2'b00);
  assign is_mwr       = (fmt[2:1] == 2'b01);
  assign is_4dw       = fmt[0];
  assign bar_sel      = bar_hit_q & BAR_MASK;
  assign supported    = (dw0_q[28:24] == 5'd0) && (is_mrd || is_mwr) && (bar_sel != 7'd0);
  assign poisoned     = dw0_q[14] | fwd_q | i_rx_err_fwd;
  assign hdr_len      = (dw0_q[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0_q[9:0]};
  // A 3DW write carries its first data DW in the upper half of beat 1.
  assign hdr_has_data = !is_4dw && (!i_rx_last || (|i_rx_strob[7:4]));

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (bar_sel[i]) bar_idx = 3'(i);
    end
  end

  // Ready in DATA looks through a DW being emitted this cycle to sustain 1 DW/clk.
  always_comb begin
    rx_ready  = 1'b0;
    pop       = (state_q == StData) && (dbuf_cnt_q != 2'd0) && i_wr_ready;
    cnt_after = dbuf_cnt_q - {1'b0, pop};
    rem_after = rem_q - {10'd0, pop};
    unique case (state_q)
      StIdle, StHdr1, StDrop: rx_ready = 1'b1;
      StData:  rx_ready = !in_last_q && (cnt_after == 2'd0) && (rem_after != 11'd0);
      default: rx_ready = 1'b0;
    endcase
  end

  assign o_rx_ready = rx_ready & ~i_rst;
  assign rx_fire    = i_rx_valid & o_rx_ready;
  assign load_cnt   = ((rem_after == 11'd1) || (i_rx_last && !(|i_rx_strob[7:4]))) ? 2'd1 : 2'd2;

  always_comb begin
    state_d    = state_q;
    dw0_d      = dw0_q;
    dw1_d      = dw1_q;
    bar_hit_d  = bar_hit_q;
    fwd_d      = fwd_q;
    hdr_last_d = hdr_last_q;
    req_d      = req_q;
    dbuf_d     = dbuf_q;
    dbuf_cnt_d = dbuf_cnt_q;
    rd_d       = rd_q;
    rem_d      = rem_q;
    in_last_d  = in_last_q;
    first_d    = first_q;
    unsup_d    = 1'b0;
    poison_d   = 1'b0;
    malf_d     = 1'b0;
    if (pop) begin
      rd_d       = ~rd_q;
      dbuf_cnt_d = cnt_after;
      rem_d      = rem_after;
      first_d    = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          dw0_d     = i_rx_data[31:0];
          dw1_d     = i_rx_data[63:32];
          bar_hit_d = i_rx_bar_hit;
          fwd_d     = i_rx_err_fwd;
          if (i_rx_last) malf_d = 1'b1;
          else           state_d = StHdr1;
        end
      end
      StHdr1: begin
        if (rx_fire) begin
          if (!supported) begin
            unsup_d = 1'b1;
            state_d = i_rx_last ? StIdle : StDrop;
          end else if (poisoned) begin
            poison_d = 1'b1;
            state_d  = i_rx_last ? StIdle : StDrop;
          end else begin
            state_d    = StReq;
            hdr_last_d = i_rx_last;
            req_d.write = is_mwr;
            req_d.addr  = is_4dw ? {i_rx_data[31:0], i_rx_data[63:34], 2'b00}
                                 : {32'd0, i_rx_data[31:2], 2'b00};
            req_d.len   = hdr_len;
            req_d.fbe   = dw1_q[3:0];
            req_d.lbe   = dw1_q[7:4];
            req_d.rid   = dw1_q[31:16];
            req_d.tag   = dw1_q[15:8];
            req_d.tc    = dw0_q[22:20];
            req_d.attr  = dw0_q[13:12];
            req_d.bar   = bar_idx;
            rem_d       = hdr_len;
            in_last_d   = i_rx_last;
            first_d     = 1'b1;
            rd_d        = 1'b0;
            dbuf_d[0]   = i_rx_data[63:32];
            dbuf_cnt_d  = (is_mwr && hdr_has_data) ? 2'd1 : 2'd0;
            if (is_mwr && i_rx_last && ({9'd0, dbuf_cnt_d} < hdr_len)) malf_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (i_req_ready) begin
          if (req_q.write)     state_d = StData;
          else if (hdr_last_q) state_d = StIdle;
          else begin
            malf_d  = 1'b1;
            state_d = StDrop;
          end
        end
      end
      StData: begin
        if (rx_fire) begin
          dbuf_d     = i_rx_data;
          dbuf_cnt_d = load_cnt;
          rd_d       = 1'b0;
          if (i_rx_last) begin
            in_last_d = 1'b1;
            if ({9'd0, load_cnt} < rem_after) malf_d = 1'b1;
          end
        end else if (cnt_after == 2'd0) begin
          if (in_last_q) state_d = StIdle;
          else if (rem_after == 11'd0) begin
            malf_d  = 1'b1;
            state_d = StDrop;
          end
        end
      end
      StDrop: begin
        if (rx_fire && i_rx_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      dw0_q      <= '0;
      dw1_q      <= '0;
      bar_hit_q  <= '0;
      fwd_q      <= 1'b0;
      hdr_last_q <= 1'b0;
      req_q      <= '0;
      dbuf_q     <= '0;
      dbuf_cnt_q <= '0;
      rd_q       <= 1'b0;
      rem_q      <= '0;
      in_last_q  <= 1'b0;
      first_q    <= 1'b0;
      unsup_q    <= 1'b0;
      poison_q   <= 1'b0;
      malf_q     <= 1'b0;
      ecrc_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dw0_q      <= dw0_d;
      dw1_q      <= dw1_d;
      bar_hit_q  <= bar_hit_d;
      fwd_q      <= fwd_d;
      hdr_last_q <= hdr_last_d;
      req_q      <= req_d;
      dbuf_q     <= dbuf_d;
      dbuf_cnt_q <= dbuf_cnt_d;
      rd_q       <= rd_d;
      rem_q      <= rem_d;
      in_last_q  <= in_last_d;
      first_q    <= first_d;
      unsup_q    <= unsup_d;
      poison_q   <= poison_d;
      malf_q     <= malf_d;
      ecrc_q     <= rx_fire & i_rx_last & i_rx_ecrc_err;
    end
  end

  assign o_req_valid = (state_q == StReq);
  assign o_req_write = req_q.write;
  assign o_req_addr  = req_q.addr;
  assign o_req_len   = req_q.len;
  assign o_req_fbe   = req_q.fbe;
  assign o_req_lbe   = req_q.lbe;
  assign o_req_rid   = req_q.rid;
  assign o_req_tag   = req_q.tag;
  assign o_req_tc    = req_q.tc;
  assign o_req_attr  = req_q.attr;
  assign o_req_bar   = req_q.bar;

  // The last buffered DW is forced to carry last when the TLP ended short.
  always_comb begin
    o_wr_valid = (state_q == StData) && (dbuf_cnt_q != 2'd0);
    o_wr_data  = '0;
    o_wr_strb  = '0;
    o_wr_last  = 1'b0;
    if (o_wr_valid) begin
      o_wr_data = dbuf_q[rd_q];
      o_wr_strb = first_q ? req_q.fbe : (rem_q == 11'd1) ? req_q.lbe : 4'hF;
      o_wr_last = (rem_q == 11'd1) || (in_last_q && (dbuf_cnt_q == 2'd1));
    end
  end

  assign o_err_unsup     = unsup_q;
  assign o_err_poison    = poison_q;
  assign o_err_malformed = malf_q;
  assign o_err_ecrc      = ecrc_q;

endmodule
